// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: FSM state codes, next-PC select and parameter defaults.
// FETCH_SEQ_PERF_EN adds the saturating-increment helper used by the perf counters.
package fetch_sequencer_pkg;

  typedef logic [1:0] fetch_seq_state_t;

  localparam fetch_seq_state_t ST_BOOT  = 2'd0;
  localparam fetch_seq_state_t ST_RUN   = 2'd1;
  localparam fetch_seq_state_t ST_FLUSH = 2'd2;
  localparam fetch_seq_state_t ST_HALT  = 2'd3;

  // Encoding is shared with cu_if_t, so the values are pinned.
  typedef enum logic [1:0] {
    SEL_KEEP       = 2'd0,
    SEL_BP_OR_PC_4 = 2'd1,
    SEL_JUMP       = 2'd2,
    SEL_DEBUG      = 2'd3
  } next_pc_sel_t;

  localparam int unsigned FETCH_RETRY_TIMEOUT = 16;
  localparam int unsigned FETCH_MAX_RETRIES   = 3;
  localparam int unsigned FETCH_FLUSH_CYCLES  = 4;

`ifdef FETCH_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/icache bundle between the control unit, debug module, icache and the fetch sequencer.
// FETCH_SEQ_PERF_EN adds the four 32-bit perf counter outputs.
interface fetch_sequencer_if;

  // Handshake: icache_resp_valid_i is a single-cycle strobe with no back-pressure; the
  // sequencer qualifies it in the same cycle with resp_keep_o (0 means drop it as stale).
  logic stall_i;
  logic redirect_i;
  logic debug_halt_req_i;
  logic debug_resume_i;
  logic fence_i_req_i;
  logic icache_ready_i;
  logic icache_resp_valid_i;

  fetch_sequencer_pkg::next_pc_sel_t     next_pc_sel_o;
  logic                                  invalidate_icache_o;
  logic                                  invalidate_buffer_o;
  logic                                  retry_fetch_o;
  logic                                  stall_debug_o;
  logic                                  debug_halted_o;
  logic                                  fence_done_o;
  logic                                  resp_keep_o;
  logic                                  fetch_err_o;
  fetch_sequencer_pkg::fetch_seq_state_t fsm_state_o;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_cyc_o;
  logic [31:0] perf_retry_o;
  logic [31:0] perf_redirect_o;
  logic [31:0] perf_drop_o;

  modport master (
    output stall_i, redirect_i, debug_halt_req_i, debug_resume_i, fence_i_req_i,
           icache_ready_i, icache_resp_valid_i,
    input  next_pc_sel_o, invalidate_icache_o, invalidate_buffer_o, retry_fetch_o,
           stall_debug_o, debug_halted_o, fence_done_o, resp_keep_o, fetch_err_o, fsm_state_o,
           perf_stall_cyc_o, perf_retry_o, perf_redirect_o, perf_drop_o
  );
  modport slave (
    input  stall_i, redirect_i, debug_halt_req_i, debug_resume_i, fence_i_req_i,
           icache_ready_i, icache_resp_valid_i,
    output next_pc_sel_o, invalidate_icache_o, invalidate_buffer_o, retry_fetch_o,
           stall_debug_o, debug_halted_o, fence_done_o, resp_keep_o, fetch_err_o, fsm_state_o,
           perf_stall_cyc_o, perf_retry_o, perf_redirect_o, perf_drop_o
  );
`else
  modport master (
    output stall_i, redirect_i, debug_halt_req_i, debug_resume_i, fence_i_req_i,
           icache_ready_i, icache_resp_valid_i,
    input  next_pc_sel_o, invalidate_icache_o, invalidate_buffer_o, retry_fetch_o,
           stall_debug_o, debug_halted_o, fence_done_o, resp_keep_o, fetch_err_o, fsm_state_o
  );
  modport slave (
    input  stall_i, redirect_i, debug_halt_req_i, debug_resume_i, fence_i_req_i,
           icache_ready_i, icache_resp_valid_i,
    output next_pc_sel_o, invalidate_icache_o, invalidate_buffer_o, retry_fetch_o,
           stall_debug_o, debug_halted_o, fence_done_o, resp_keep_o, fetch_err_o, fsm_state_o
  );
`endif

endinterface

// File: rtl/fetch_sequencer_retry_timer.sv
// Fetch timeout timer: counts wait cycles of the outstanding request, pulses on timeout,
// counts consecutive retries and raises a sticky error once the retry budget is spent.
module fetch_sequencer_retry_timer #(
  parameter int unsigned RETRY_TIMEOUT = 16,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic count_en_i,
  input  logic clear_i,
  input  logic resp_i,
  input  logic err_clear_i,
  output logic timeout_pulse_o,
  output logic err_o
);

  localparam logic [7:0] TIMER_LAST = 8'(RETRY_TIMEOUT - 1);
  localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRIES);

  logic [7:0] timer_q, timer_d;
  logic [3:0] retry_cnt_q, retry_cnt_d;
  logic       err_q, err_d;
  logic       hit, err_set;

  always_comb begin
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    hit         = 1'b0;
    err_set     = 1'b0;
    if (clear_i || resp_i) begin
      timer_d     = 8'd0;
      retry_cnt_d = 4'd0;
    end else if (count_en_i) begin
      if (timer_q == TIMER_LAST) begin
        hit     = 1'b1;
        timer_d = 8'd0;
        // Budget exhausted: flag the error and leave the count saturated.
        if (retry_cnt_q == RETRY_MAX) err_set = 1'b1;
        else                          retry_cnt_d = retry_cnt_q + 4'd1;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
    if (err_clear_i)  err_d = 1'b0;
    else if (err_set) err_d = 1'b1;
    else              err_d = err_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer_q     <= 8'd0;
      retry_cnt_q <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      err_q       <= err_d;
    end
  end

  assign timeout_pulse_o = hit;
  assign err_o           = err_q | err_set;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: picks the next-PC source for if_stage_1 and drives icache flush/retry and
// debug halt. Define FETCH_SEQ_PERF_EN to add saturating perf counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned RETRY_TIMEOUT = FETCH_RETRY_TIMEOUT,
  parameter int unsigned MAX_RETRIES   = FETCH_MAX_RETRIES,
  parameter int unsigned FLUSH_CYCLES  = FETCH_FLUSH_CYCLES
) (
  input logic              clk_i,
  input logic              rstn_i,
  fetch_sequencer_if.slave bus
);

  localparam logic [4:0] FLUSH_MIN = 5'(FLUSH_CYCLES);

  fetch_seq_state_t state_q, state_d;
  logic             outstanding_q, outstanding_d;
  logic             kill_q, kill_d;
  logic             redir_pend_q, redir_pend_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;

  next_pc_sel_t sel;
  logic inv_ic, inv_buf, done, keep, sdbg, halted;
  logic tmr_clear, err_clear, count_en, timeout, fetch_err, resp;

  assign resp     = bus.icache_resp_valid_i;
  assign count_en = outstanding_q & ~resp & ~bus.stall_i;

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q & ~resp;
    kill_d        = kill_q & ~resp;
    redir_pend_d  = redir_pend_q;
    flush_cnt_d   = flush_cnt_q;
    sel           = SEL_KEEP;
    inv_ic        = 1'b0;
    inv_buf       = 1'b0;
    done          = 1'b0;
    keep          = 1'b0;
    sdbg          = 1'b0;
    halted        = 1'b0;
    tmr_clear     = 1'b0;
    err_clear     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.debug_halt_req_i) begin
          state_d = ST_HALT;
        end else if (bus.redirect_i) begin
          sel       = SEL_JUMP;
          inv_buf   = 1'b1;
          // A response landing this cycle is already dropped, so only a still-pending one is killed.
          kill_d    = outstanding_q & ~resp;
          tmr_clear = 1'b1;
          err_clear = 1'b1;
        end else if (bus.fence_i_req_i) begin
          inv_ic        = 1'b1;
          inv_buf       = 1'b1;
          state_d       = ST_FLUSH;
          flush_cnt_d   = 4'd0;
          redir_pend_d  = 1'b0;
          outstanding_d = 1'b0;
          kill_d        = 1'b0;
          tmr_clear     = 1'b1;
        end else begin
          keep = resp & ~kill_q;
          if (!bus.stall_i) begin
            outstanding_d = 1'b1;
            if (keep) sel = SEL_BP_OR_PC_4;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q != 4'hF) flush_cnt_d = flush_cnt_q + 4'd1;
        if (bus.redirect_i) redir_pend_d = 1'b1;
        // flush_cnt_q counts earlier FLUSH cycles; this cycle is number flush_cnt_q+1.
        if ((({1'b0, flush_cnt_q} + 5'd1) >= FLUSH_MIN) && bus.icache_ready_i) begin
          done    = 1'b1;
          state_d = ST_RUN;
          if (redir_pend_q || bus.redirect_i) begin
            sel       = SEL_JUMP;
            inv_buf   = 1'b1;
            tmr_clear = 1'b1;
            err_clear = 1'b1;
          end else begin
            sel = SEL_BP_OR_PC_4;
          end
        end
      end
      default: begin
        sdbg   = 1'b1;
        halted = ~outstanding_q;
        if (halted && bus.debug_resume_i) begin
          sel       = SEL_DEBUG;
          inv_buf   = 1'b1;
          state_d   = ST_RUN;
          kill_d    = 1'b0;
          tmr_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_BOOT;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      redir_pend_q  <= 1'b0;
      flush_cnt_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      redir_pend_q  <= redir_pend_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  fetch_sequencer_retry_timer #(
    .RETRY_TIMEOUT (RETRY_TIMEOUT),
    .MAX_RETRIES   (MAX_RETRIES)
  ) u_retry_timer (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .count_en_i      (count_en),
    .clear_i         (tmr_clear),
    .resp_i          (resp),
    .err_clear_i     (err_clear),
    .timeout_pulse_o (timeout),
    .err_o           (fetch_err)
  );

  assign bus.next_pc_sel_o       = sel;
  assign bus.invalidate_icache_o = inv_ic;
  assign bus.invalidate_buffer_o = inv_buf;
  assign bus.retry_fetch_o       = timeout;
  assign bus.stall_debug_o       = sdbg;
  assign bus.debug_halted_o      = halted;
  assign bus.fence_done_o        = done;
  assign bus.resp_keep_o         = keep;
  assign bus.fetch_err_o         = fetch_err;
  assign bus.fsm_state_o         = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic        stall_taken;
  logic [31:0] perf_stall_q, perf_retry_q, perf_redirect_q, perf_drop_q;

  assign stall_taken = (state_q == ST_RUN) & ~bus.debug_halt_req_i & ~bus.redirect_i &
                       ~bus.fence_i_req_i & bus.stall_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_stall_q    <= 32'd0;
      perf_retry_q    <= 32'd0;
      perf_redirect_q <= 32'd0;
      perf_drop_q     <= 32'd0;
    end else begin
      if (stall_taken)      perf_stall_q    <= sat_inc32(perf_stall_q);
      if (timeout)          perf_retry_q    <= sat_inc32(perf_retry_q);
      if (sel == SEL_JUMP)  perf_redirect_q <= sat_inc32(perf_redirect_q);
      if (resp && !keep)    perf_drop_q     <= sat_inc32(perf_drop_q);
    end
  end

  assign bus.perf_stall_cyc_o = perf_stall_q;
  assign bus.perf_retry_o     = perf_retry_q;
  assign bus.perf_redirect_o  = perf_redirect_q;
  assign bus.perf_drop_o      = perf_drop_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int RT = 16;
  localparam int MR = 3;
  localparam int FC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RETRY_TIMEOUT(RT), .MAX_RETRIES(MR), .FLUSH_CYCLES(FC)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  typedef enum int {M_BOOT, M_RUN, M_FLUSH, M_HALT} mmode_t;
  mmode_t m_mode, n_mode;
  bit m_out, n_out, m_stale, n_stale, m_pend, n_pend, m_err, n_err;
  int m_flush, n_flush, m_wait, n_wait, m_retries, n_retries;
  int e_sel;
  bit e_ic, e_buf, e_retry, e_sdbg, e_halted, e_done, e_keep, e_err, e_stall_cnt, e_resp;
  int pm_stall, pm_retry, pm_redir, pm_drop;

  logic [1:0] cap_sel, cap_state;
  logic cap_keep, cap_done, cap_halted, cap_retry, cap_err, cap_ic, cap_buf;

  function automatic logic [1:0] mode_code(input mmode_t m);
    case (m)
      M_BOOT:  return ST_BOOT;
      M_RUN:   return ST_RUN;
      M_FLUSH: return ST_FLUSH;
      default: return ST_HALT;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT; m_out = 0; m_stale = 0; m_pend = 0; m_err = 0;
    m_flush = 0; m_wait = 0; m_retries = 0;
    pm_stall = 0; pm_retry = 0; pm_redir = 0; pm_drop = 0;
  endtask

  task automatic model_eval();
    bit resp, clr, err_clr, err_set;
    resp = bus.icache_resp_valid_i;
    e_resp = resp;
    e_sel = SEL_KEEP; e_ic = 0; e_buf = 0; e_retry = 0; e_sdbg = 0; e_halted = 0;
    e_done = 0; e_keep = 0; e_stall_cnt = 0;
    n_mode = m_mode; n_out = m_out && !resp; n_stale = m_stale && !resp;
    n_flush = m_flush; n_pend = m_pend;
    clr = 0; err_clr = 0; err_set = 0;
    case (m_mode)
      M_BOOT: n_mode = M_RUN;
      M_RUN: begin
        if (bus.debug_halt_req_i) n_mode = M_HALT;
        else if (bus.redirect_i) begin
          e_sel = SEL_JUMP; e_buf = 1; n_stale = m_out && !resp; clr = 1; err_clr = 1;
        end else if (bus.fence_i_req_i) begin
          e_ic = 1; e_buf = 1; n_mode = M_FLUSH; n_flush = 0; n_pend = 0;
          n_out = 0; n_stale = 0; clr = 1;
        end else begin
          e_keep = resp && !m_stale;
          if (bus.stall_i) e_stall_cnt = 1;
          else begin
            n_out = 1;
            if (e_keep) e_sel = SEL_BP_OR_PC_4;
          end
        end
      end
      M_FLUSH: begin
        n_flush = m_flush + 1;
        if (bus.redirect_i) n_pend = 1;
        if (m_flush + 1 >= FC && bus.icache_ready_i) begin
          e_done = 1; n_mode = M_RUN;
          if (m_pend || bus.redirect_i) begin
            e_sel = SEL_JUMP; e_buf = 1; clr = 1; err_clr = 1;
          end else e_sel = SEL_BP_OR_PC_4;
        end
      end
      default: begin
        e_sdbg = 1; e_halted = !m_out;
        if (e_halted && bus.debug_resume_i) begin
          e_sel = SEL_DEBUG; e_buf = 1; n_mode = M_RUN; n_stale = 0; clr = 1;
        end
      end
    endcase
    n_wait = m_wait; n_retries = m_retries;
    if (clr || resp) begin
      n_wait = 0; n_retries = 0;
    end else if (m_out && !bus.stall_i) begin
      if (m_wait + 1 == RT) begin
        e_retry = 1; n_wait = 0;
        if (m_retries == MR) err_set = 1;
        else n_retries = m_retries + 1;
      end else n_wait = m_wait + 1;
    end
    e_err = m_err || err_set;
    n_err = err_clr ? 1'b0 : e_err;
  endtask

  task automatic model_commit();
    m_mode = n_mode; m_out = n_out; m_stale = n_stale; m_pend = n_pend; m_err = n_err;
    m_flush = n_flush; m_wait = n_wait; m_retries = n_retries;
    pm_stall += int'(e_stall_cnt);
    pm_retry += int'(e_retry);
    pm_redir += int'(e_sel == SEL_JUMP);
    pm_drop  += int'(e_resp && !e_keep);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit st, input bit rd, input bit hq, input bit rs,
                       input bit fc, input bit rdy, input bit rv);
    bus.stall_i = st; bus.redirect_i = rd; bus.debug_halt_req_i = hq;
    bus.debug_resume_i = rs; bus.fence_i_req_i = fc; bus.icache_ready_i = rdy;
    bus.icache_resp_valid_i = rv;
  endtask

  // One cycle: inputs already driven after a negedge; sample mid-low-phase, then clock.
  task automatic step();
    #2;
    model_eval();
    cap_sel = bus.next_pc_sel_o;   cap_state = bus.fsm_state_o;
    cap_keep = bus.resp_keep_o;    cap_done = bus.fence_done_o;
    cap_halted = bus.debug_halted_o; cap_retry = bus.retry_fetch_o;
    cap_err = bus.fetch_err_o;     cap_ic = bus.invalidate_icache_o;
    cap_buf = bus.invalidate_buffer_o;
    chk("sel", cap_sel, e_sel);
    chk("state", cap_state, mode_code(m_mode));
    chk("resp_keep", cap_keep, e_keep);
    chk("inv_icache", cap_ic, e_ic);
    chk("inv_buffer", cap_buf, e_buf);
    chk("retry", cap_retry, e_retry);
    chk("stall_debug", bus.stall_debug_o, e_sdbg);
    chk("halted", cap_halted, e_halted);
    chk("fence_done", cap_done, e_done);
    chk("fetch_err", cap_err, e_err);
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, bus.fsm_state_o, ST_BOOT);
    chk({tag, "_sel"}, bus.next_pc_sel_o, SEL_KEEP);
    chk({tag, "_outs"}, {bus.invalidate_icache_o, bus.invalidate_buffer_o, bus.retry_fetch_o,
        bus.stall_debug_o, bus.debug_halted_o, bus.fence_done_o, bus.resp_keep_o,
        bus.fetch_err_o}, 0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    drive(0, 1, 0, 1, 1, 1, 1);
    #1;
    check_reset_outputs("reset");
    drive(0, 0, 0, 0, 0, 1, 1);
    rstn = 1'b1;

    // 1: response every cycle from reset release
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t1_sel", cap_sel, (c == 0) ? SEL_KEEP : SEL_BP_OR_PC_4);
    end

    // 2: redirect at cycle 5 with request outstanding, stale response at cycle 7
    for (int c = 0; c < 9; c++) begin
      drive(0, c == 5, 0, 0, 0, 1, c >= 7);
      step();
      if (c == 5) chk("t2_jump", {cap_sel, cap_buf}, {SEL_JUMP, 1'b1});
      if (c == 7) chk("t2_drop", cap_keep, 0);
      if (c == 8) chk("t2_live", cap_keep, 1);
    end

    // 3: fence with icache busy until cycle 10
    for (int c = 0; c <= 10; c++) begin
      drive(0, 0, 0, 0, c == 0, c >= 10, 0);
      step();
      if (c == 0) chk("t3_inv_icache", cap_ic, 1);
      if (c == 9) chk("t3_not_done", cap_done, 0);
      if (c == 10) chk("t3_done", cap_done, 1);
    end

    // 4: no responses -> retries at 16/32/48/64, error from 64, cleared by redirect
    exp_q = '{32'd16, 32'd32, 32'd48, 32'd64};
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 70; c++) begin
      step();
      if (cap_retry) got_q.push_back(32'(c));
      if (c == 63) chk("t4_err_before", cap_err, 0);
      if (c == 64) chk("t4_err_at_64", cap_err, 1);
    end
    chk("t4_retry_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("t4_retry_cycle", got_q.pop_front(), exp_q.pop_front());
    drive(0, 1, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    chk("t4_err_cleared", cap_err, 0);

    // 5: halt with request outstanding, response 3 cycles later, early resume ignored
    for (int h = 0; h < 6; h++) begin
      drive(0, 0, h == 0, (h == 2) || (h == 5), 0, 1, h == 3);
      step();
      if (h == 2) chk("t5_resume_ignored", cap_sel, SEL_KEEP);
      if (h == 3) chk("t5_not_halted", cap_halted, 0);
      if (h == 4) chk("t5_halted", cap_halted, 1);
      if (h == 5) chk("t5_debug_sel", cap_sel, SEL_DEBUG);
    end

    // 6: redirect beats fence; then reset asserted while in FLUSH
    drive(0, 1, 0, 0, 1, 1, 0);
    step();
    chk("t6_jump", cap_sel, SEL_JUMP);
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("t6_no_flush", cap_state, ST_RUN);
    drive(0, 0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("t6_in_flush", cap_state, ST_FLUSH);
    drive(1, 1, 1, 1, 1, 1, 1);
    #3 rstn = 1'b0;
    #1 check_reset_outputs("t6_reset");
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 1);
    rstn = 1'b1;
    step();
    chk("t6_boot_keep", cap_sel, SEL_KEEP);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(99, 0) < 20, $urandom_range(99, 0) < 6, $urandom_range(99, 0) < 3,
            $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 3, $urandom_range(99, 0) < 60,
            $urandom_range(99, 0) < 40);
      step();
    end

`ifdef FETCH_SEQ_PERF_EN
    chk("perf_stall", bus.perf_stall_cyc_o, 32'(pm_stall));
    chk("perf_retry", bus.perf_retry_o, 32'(pm_retry));
    chk("perf_redirect", bus.perf_redirect_o, 32'(pm_redir));
    chk("perf_drop", bus.perf_drop_o, 32'(pm_drop));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
